// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared state type and sizing helpers for the carry-save Montgomery multiplier.
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mont_state_t;

  // One extra iteration beyond the operand width keeps the result below 2n.
  function automatic int mont_iters(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int mont_cnt_width(input int data_width);
    return $clog2(mont_iters(data_width) + 1);
  endfunction

endpackage

// File: rtl/csa_4to2.sv
// rtl/csa_4to2.sv - combinational row of W 4:2 compressors; carry output is already left-shifted.
module csa_4to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] p;
  logic [W-1:0] maj1;
  logic [W-1:0] cin;
  logic [W-1:0] maj2;

  // First full adder per column; its carry ripples exactly one column into the second adder.
  assign p    = x0 ^ x1 ^ x2;
  assign maj1 = (x0 & x1) | (x0 & x2) | (x1 & x2);
  assign cin  = {maj1[W-2:0], 1'b0};

  assign sum  = p ^ x3 ^ cin;
  assign maj2 = (p & x3) | (p & cin) | (x3 & cin);
  assign carry = {maj2[W-2:0], 1'b0};

endmodule

// File: rtl/mont_mult_cs.sv
// rtl/mont_mult_cs.sv - radix-2 bit-serial Montgomery multiplier, carry-save accumulator.
// MONT_MULT_INPUT_REG_EN: capture a/b/n at start instead of requiring them held stable.
module mont_mult_cs
  import mont_pkg::*;
#(
  parameter int DATA_WIDTH = 1025
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] n,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] s0,
  output logic [DATA_WIDTH-1:0] s1
);

  localparam int K  = mont_iters(DATA_WIDTH);
  localparam int CW = mont_cnt_width(DATA_WIDTH);
  localparam int SW = DATA_WIDTH + 1;
  localparam int RW = DATA_WIDTH + 2;

  mont_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] s0_q, s1_q;
  logic          load, step;
  logic          a_bit, q;
  logic [DATA_WIDTH-1:0] b_op, n_op;
  logic [RW-1:0] x2, x3, row_sum, row_carry;

`ifdef MONT_MULT_INPUT_REG_EN
  logic [DATA_WIDTH-1:0] a_q, b_q, n_q;
  assign a_bit = a_q[0];
  assign b_op  = b_q;
  assign n_op  = n_q;
`else
  // Past the operand width the shift yields zero, matching a[i] = 0 for i >= DATA_WIDTH.
  assign a_bit = 1'(a >> cnt_q);
  assign b_op  = b;
  assign n_op  = n;
`endif

  assign q  = s0_q[0] ^ s1_q[0] ^ (a_bit & b_op[0]);
  assign x2 = a_bit ? {2'b00, b_op} : '0;
  assign x3 = q ? {2'b00, n_op} : '0;

  csa_4to2 #(.W(RW)) u_csa (
    .x0    ({1'b0, s0_q}),
    .x1    ({1'b0, s1_q}),
    .x2    (x2),
    .x3    (x3),
    .sum   (row_sum),
    .carry (row_carry)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(K - 1)) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
`ifdef MONT_MULT_INPUT_REG_EN
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
`endif
    end else if (ce) begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= '0;
        s0_q  <= '0;
        s1_q  <= '0;
`ifdef MONT_MULT_INPUT_REG_EN
        a_q   <= a;
        b_q   <= b;
        n_q   <= n;
`endif
      end else if (step) begin
        // Row total is even, so the halving drops only zero bits.
        cnt_q <= cnt_q + 1'b1;
        s0_q  <= SW'(row_sum >> 1);
        s1_q  <= SW'(row_carry >> 1);
`ifdef MONT_MULT_INPUT_REG_EN
        a_q   <= a_q >> 1;
`endif
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign s0   = s0_q[DATA_WIDTH-1:0];
  assign s1   = s1_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_mont_mult_cs.sv
// tb/tb_mont_mult_cs.sv - directed self-checking bench for mont_mult_cs at DATA_WIDTH = 9.
module tb_mont_mult_cs;

  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          start;
  logic [DW-1:0] a, b, n;
  logic          busy, done;
  logic [DW-1:0] s0, s1;

  int checks = 0;
  int failures = 0;
  int cyc;
  int extra;

  always #5 clk = ~clk;

  mont_mult_cs #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .start (start),
    .a     (a),
    .b     (b),
    .n     (n),
    .busy  (busy),
    .done  (done),
    .s0    (s0),
    .s1    (s1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tot();
    return 32'(s0) + 32'(s1);
  endfunction

  task automatic wait_done(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!done && c < 100);
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic launch(input logic [DW-1:0] aa, input logic [DW-1:0] bb, input logic [DW-1:0] nn);
    a = aa;
    b = bb;
    n = nn;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; start = 1'b0; a = '0; b = '0; n = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s0", 32'(s0), 0);
    chk("rst_s1", 32'(s1), 0);
    rst = 1'b0;
    tick();

    // 5*7*2^-10 mod 13 = 10
    launch(9'd5, 9'd7, 9'd13);
    chk("s1_busy", 32'(busy), 1);
    wait_done(cyc);
    chk("s1_latency", cyc, 10);
    chk("s1_mod", tot() % 13, 10);
    chk("s1_lt2n", 32'(tot() < 26), 1);
    tick();
    chk("s1_done_clear", 32'(done), 0);
    chk("s1_idle_busy", 32'(busy), 0);

    // 254*254*2^-10 mod 255 = 64
    launch(9'd254, 9'd254, 9'd255);
    wait_done(cyc);
    chk("s2_latency", cyc, 10);
    chk("s2_mod", tot() % 255, 64);
    chk("s2_lt2n", 32'(tot() < 510), 1);
    chk("s2_top_s0", 32'(dut.s0_q[DW]), 0);
    chk("s2_top_s1", 32'(dut.s1_q[DW]), 0);
    tick();

    launch(9'd0, 9'd12, 9'd13);
    wait_done(cyc);
    chk("s3_s0_zero", 32'(s0), 0);
    chk("s3_s1_zero", 32'(s1), 0);
    tick();

    // Second start at E5 ignored, 3 stalled cycles stretch latency to 13
    launch(9'd5, 9'd7, 9'd13);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    ce = 1'b0;
    repeat (3) tick();
    chk("s4_stall_no_done", 32'(done), 0);
    ce = 1'b1;
    wait_done(cyc);
    chk("s4_latency", cyc + 8, 13);
    chk("s4_mod", tot() % 13, 10);
    ce = 1'b0;
    tick();
    chk("s4_done_held", 32'(done), 1);
    ce = 1'b1;
    tick();
    chk("s4_done_clear", 32'(done), 0);
    count_dones(20, extra);
    chk("s4_extra_done", extra, 0);

    // Back-to-back: start during done cycle, 3*4*2^-10 mod 13 = 9
    launch(9'd5, 9'd7, 9'd13);
    wait_done(cyc);
    chk("s5_first_mod", tot() % 13, 10);
    a = 9'd3;
    b = 9'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s5_busy_b2b", 32'(busy), 1);
    chk("s5_no_done", 32'(done), 0);
    wait_done(cyc);
    chk("s5_latency", cyc, 10);
    chk("s5_mod", tot() % 13, 9);
    tick();

    // Asynchronous reset mid-run
    launch(9'd5, 9'd7, 9'd13);
    repeat (3) tick();
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("s6_busy", 32'(busy), 0);
    chk("s6_done", 32'(done), 0);
    chk("s6_s0", 32'(s0), 0);
    chk("s6_s1", 32'(s1), 0);
    repeat (2) tick();
    rst = 1'b0;
    count_dones(20, extra);
    chk("s6_no_done", extra, 0);
    launch(9'd5, 9'd7, 9'd13);
    wait_done(cyc);
    chk("s6_latency", cyc, 10);
    chk("s6_mod", tot() % 13, 10);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mont_mult_cs.md
# mont_mult_cs

Radix-2 bit-serial Montgomery multiplier that keeps its accumulator in carry-save form, producing the pair (s0, s1) whose sum is congruent to a·b·2^-K mod n. It sits directly upstream of the final carry-propagate adder stage. Its `done` pulse drives that stage's `start_final_addition`, and its `s0`/`s1` drive `s0_r`/`s1_r`. No carry propagates across the full width, so the per-cycle critical path is one 4:2 compressor row.

## Interface
Parameters:
- DATA_WIDTH, 1025 (1024+1): operand and output width.
- K (localparam), DATA_WIDTH+1: number of iterations, so R = 2^K.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable. While low, all state holds.
- start  in  1  request a multiplication. Sampled on a ce edge.
- a  in  DATA_WIDTH  multiplier; consumed LSB first.
- b  in  DATA_WIDTH  multiplicand.
- n  in  DATA_WIDTH  modulus; must be odd.
- busy  out  1  high in states RUN and DONE.
- done  out  1  one-cycle pulse; s0/s1 are valid only while done is high.
- s0  out  DATA_WIDTH  carry-save sum vector.
- s1  out  DATA_WIDTH  carry-save carry vector.

## Operation
- Preconditions: n odd; a < 2n; b < 2n; 4n < 2^K.
- Result: (s0 + s1) ≡ a·b·2^-K (mod n), and s0 + s1 < 2n.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE when cnt == K-1 and the last iteration executes.
  - DONE → RUN on start (back-to-back operation); otherwise DONE → IDLE.
- On accepting start: S0 = 0, S1 = 0, cnt = 0.
- Each RUN cycle (i = cnt):
  - q = S0[0] ^ S1[0] ^ (a[i] & b[0]).
  - Compress S0, S1, a[i]·b and q·n through one 4:2 row to (sum, carry).
  - S0 ← sum >> 1; S1 ← carry >> 1; cnt ← cnt + 1.
  - The total is even by construction, so the shift discards no information.
- For i ≥ DATA_WIDTH, a[i] = 0.
- Widths:
  - Compressor row is DATA_WIDTH+2 bits.
  - S0 and S1 registers are DATA_WIDTH+1 bits.
  - Outputs s0/s1 are the low DATA_WIDTH bits. Under the preconditions the top bit is zero when done is high.
- start while in RUN: ignored, with no effect on the operation in flight.
- Reset mid-operation: FSM returns to IDLE and all registers go to 0. No done is issued.

## Timing
- Reset values: busy = 0, done = 0, s0 = 0, s1 = 0. Internal cnt = 0.
- Edge numbering: start is accepted at edge E0; iterations execute at ce edges E1..EK.
- done is high from EK until the next ce edge. Latency is K enabled cycles, i.e. 1026 for the default DATA_WIDTH.
- ce low stretches every state, including DONE, by the number of stalled cycles.
- busy rises at E0 and falls when the FSM enters IDLE.
- s0/s1 change every RUN cycle. The downstream stage must capture them on done.
- Without MONT_MULT_INPUT_REG_EN, a/b/n must be held stable from E0 through EK.

## Configuration
- MONT_MULT_INPUT_REG_EN, defined:
  - a, b and n are captured into internal registers at E0.
  - Callers may change the inputs immediately after E0.
  - a is shifted right each iteration, so a[i] is bit 0 of the shift register.
- MONT_MULT_INPUT_REG_EN, undefined:
  - No operand registers; saves 3·DATA_WIDTH flops.
  - a[i] is selected by a cnt-indexed mux.
  - Inputs must be held stable as stated under Timing.
- Results are identical in both configurations.

## Structure
- Shared package mont_pkg holds:
  - The typedef mont_state_t {IDLE, RUN, DONE}.
  - A function mont_iters(DATA_WIDTH) returning K.
  - The counter width $clog2(K+1).
- Sub-module csa_4to2 #(W): a purely combinational row of W 4:2 compressors, outputs sum[W-1:0] and carry[W-1:0] (carry already left-shifted). Instantiated once with W = DATA_WIDTH+2.

## Test plan
All scenarios use DATA_WIDTH = 9, so K = 10 and R = 1024; each checks s0 + s1 when done is high.
- n=13, a=5, b=7 → done exactly 10 enabled cycles after E0; (s0+s1) mod 13 = 10; s0+s1 < 26.
- n=255, a=254, b=254 → (s0+s1) mod 255 = 64; s0+s1 < 510; top internal bit 0.
- n=13, a=0, b=12 → s0 = s1 = 0 at done.
- n=13, a=5, b=7 with start pulsed again at E5, and ce held low for 3 cycles mid-run → second start ignored; exactly one done pulse, 13 cycles after E0; result as in the first scenario.
- Start asserted in the done cycle with a=3, b=4, n=13 → next operation begins without passing through IDLE; second done 10 cycles later; (s0+s1) mod 13 = 12·4 mod 13 = 9.
- rst asserted at E4 → busy = done = s0 = s1 = 0 immediately (asynchronously); no done afterwards; a new start completes normally.
